// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder/subtractor. A single full-adder cell is reused across
//   WIDTH clocks, consuming one operand bit per clock, LSB first.
//   A result is produced WIDTH clocks after the start edge.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only while idle
//   SUB    0: A+B+CIN, 1: A-B (captured at start)
//   A, B   operands (captured at start)
//   CIN    carry-in for add (captured at start, ignored for subtract)
//   busy   high while the bit loop is running
//   done   one-cycle pulse when S/C are updated
//   S      result, held until the next completion
//   C      carry-out (add) or no-borrow flag (sub: 1 means A >= B)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             sum;
  logic             carry_nxt;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_nxt;
  logic             last_bit;
  logic             unused_res;

  // One full-adder cell on the current LSBs.
  assign sum       = opa[0] ^ opb[0] ^ carry;
  assign carry_nxt = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);

  // New sum bit enters at the MSB; concatenation keeps WIDTH=1 legal.
  assign res_cat  = {sum, res};
  assign res_nxt  = res_cat[WIDTH:1];
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // The oldest result bit is shifted out and never needed again.
  assign unused_res = res[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      C     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtract as A + ~B + 1: invert B and seed the carry.
            opa   <= A;
            opb   <= B ^ {WIDTH{SUB}};
            carry <= SUB | CIN;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= carry_nxt;
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          res   <= res_nxt;
          if (last_bit) begin
            // Counter is left at WIDTH-1 so it never wraps.
            S     <= res_nxt;
            C     <= carry_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed bench for serial_adder: an 8-bit instance for the main
//   sequence and a 2-bit instance for the exhaustive small sweep.
//   Expected results are pushed to a queue at start and popped on done.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start, sub, cin;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] s;
  logic       c;

  logic       start2, sub2, cin2;
  logic [1:0] a2, b2;
  logic       busy2, done2;
  logic [1:0] s2;
  logic       c2;

  int         checks = 0;
  int         errors = 0;

  logic [8:0] q8[$];
  logic [2:0] q2[$];
  logic [7:0] last_s = '0;
  logic       last_c = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .SUB(sub), .A(a), .B(b),
    .CIN(cin), .busy(busy), .done(done), .S(s), .C(c)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .SUB(sub2), .A(a2), .B(b2),
    .CIN(cin2), .busy(busy2), .done(done2), .S(s2), .C(c2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {carry/no-borrow, sum}
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                      input logic ci, input logic sb);
    if (sb) return {1'b0, x} + {1'b0, ~y} + 9'd1;
    return {1'b0, x} + {1'b0, y} + {8'd0, ci};
  endfunction

  function automatic logic [2:0] ref2(input logic [1:0] x, input logic [1:0] y,
                                      input logic ci);
    return {1'b0, x} + {1'b0, y} + {2'd0, ci};
  endfunction

  // One 8-bit operation; optionally scramble the operand inputs mid-run.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic ci,
                     input logic sb, input bit scramble);
    int nb;
    int g;
    logic [8:0] e;
    @(negedge clk);
    a = x; b = y; cin = ci; sub = sb; start = 1'b1;
    q8.push_back(ref8(x, y, ci, sb));
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    g  = 0;
    while (!done && g < 40) begin
      if (busy) nb++;
      chk("s_hold_in_run", s, last_s);
      chk("c_hold_in_run", c, last_c);
      if (scramble && g == 3) begin
        a = ~x; b = x ^ y; cin = ~ci; sub = ~sb;
      end
      @(negedge clk);
      g++;
    end
    chk("done_seen", done, 1);
    chk("busy_cycles", nb, 8);
    chk("busy_low_at_done", busy, 0);
    e = q8.pop_front();
    chk("sum", s, e[7:0]);
    chk("carry", c, e[8]);
    last_s = e[7:0];
    last_c = e[8];
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic op2(input logic [1:0] x, input logic [1:0] y, input logic ci);
    int g;
    logic [2:0] e;
    @(negedge clk);
    a2 = x; b2 = y; cin2 = ci; sub2 = 1'b0; start2 = 1'b1;
    q2.push_back(ref2(x, y, ci));
    @(negedge clk);
    start2 = 1'b0;
    g = 0;
    while (!done2 && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("w2_done", done2, 1);
    chk("w2_latency", g, 2);
    e = q2.pop_front();
    chk("w2_sum", s2, e[1:0]);
    chk("w2_carry", c2, e[2]);
  endtask

  initial begin
    int cyc;
    int nd;
    int t0;
    int t1;
    logic [8:0] e;
    logic [7:0] ra, rb;
    logic rc, rs;

    // Reset held with garbage inputs and start high.
    t0 = 0;
    t1 = 0;
    start = 1'b1; a = 8'($urandom); b = 8'($urandom); cin = 1'b1; sub = 1'b0;
    start2 = 1'b1; a2 = 2'b11; b2 = 2'b10; cin2 = 1'b1; sub2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s", s, 0);
    chk("rst_c", c, 0);
    chk("rst_w2_busy", busy2, 0);
    chk("rst_w2_s", s2, 0);
    start = 1'b0; start2 = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // Directed add / carry chain.
    op8(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0);
    op8(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);

    // Exhaustive 2-bit sweep.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] iv;
      iv = 5'(i);
      op2(iv[1:0], iv[3:2], iv[4]);
    end

    // Subtract, with and without borrow.
    op8(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
    op8(8'h01, 8'h02, 1'b1, 1'b1, 1'b0);

    // Operands change after the start edge.
    op8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);

    // start held high: back-to-back operations.
    @(negedge clk);
    a = 8'h5A; b = 8'h33; cin = 1'b1; sub = 1'b0; start = 1'b1;
    q8.push_back(ref8(8'h5A, 8'h33, 1'b1, 1'b0));
    q8.push_back(ref8(8'h5A, 8'h33, 1'b1, 1'b0));
    cyc = 0;
    nd  = 0;
    while (nd < 2 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        e = q8.pop_front();
        chk("b2b_sum", s, e[7:0]);
        chk("b2b_carry", c, e[8]);
        last_s = e[7:0];
        last_c = e[8];
        if (nd == 0) t0 = cyc; else t1 = cyc;
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_count", nd, 2);
    chk("b2b_spacing", t1 - t0, 10);
    @(negedge clk);
    chk("b2b_done_low", done, 0);
    @(negedge clk);
    chk("b2b_no_third", busy, 0);

    // Reset in the middle of RUN.
    @(negedge clk);
    a = 8'h77; b = 8'h11; cin = 1'b0; sub = 1'b0; start = 1'b1;
    q8.push_back(ref8(8'h77, 8'h11, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_s", s, 0);
    chk("async_rst_c", c, 0);
    q8.delete();
    last_s = '0;
    last_c = 1'b0;
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_rst", nd, 0);
    rst_n = 1'b1;
    op8(8'hC3, 8'h5A, 1'b1, 1'b0, 1'b0);

    // A few random operations.
    repeat (4) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      op8(ra, rb, rc, rs, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
